// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// Beat counter for the serializer: synchronous clear, count enable, terminal-count flag at N-1.
module ser_bit_counter #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(N - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Framed PISO stage with valid/ready on both sides; back-to-back frames need no bubble.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity beat to every frame.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_out,
  output logic         ser_last,
  output logic         busy
);

  localparam int CW = $clog2(N);

  ser_state_t    state, next_state;
  logic [N-1:0]  shift_reg;
  logic [CW-1:0] bit_cnt;
  logic          bit_tc;
  logic          beat_xfer;
  logic          load_fire;
  logic          final_beat_xfer;
  logic          data_bit;
  logic          shift_xfer;

  assign ser_valid       = (state != IDLE);
  assign busy            = ser_valid;
  assign beat_xfer       = ser_valid & ser_ready;
  assign shift_xfer      = (state == SHIFT) & beat_xfer;
  assign final_beat_xfer = beat_xfer & ser_last;
  assign load_ready      = (state == IDLE) | final_beat_xfer;
  assign load_fire       = load_valid & load_ready;
  assign data_bit        = (MSB_FIRST != 0) ? shift_reg[N-1] : shift_reg[0];

`ifdef PISO_SERIALIZER_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (load_fire) begin
      parity_bit <= ^load_data;
    end
  end

  assign ser_out  = (state == PARITY) ? parity_bit : ((state == SHIFT) & data_bit);
  assign ser_last = (state == PARITY);
`else
  assign ser_out  = (state == SHIFT) & data_bit;
  assign ser_last = (state == SHIFT) & bit_tc;
`endif

  // Counter restarts on every load and after the last data beat, so it never wraps.
  ser_bit_counter #(.N(N)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (load_fire | (shift_xfer & bit_tc)),
    .en    (shift_xfer),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load_fire) begin
      shift_reg <= load_data;
    end else if (shift_xfer) begin
      shift_reg <= (MSB_FIRST != 0) ? {shift_reg[N-2:0], 1'b0} : {1'b0, shift_reg[N-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets its default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_fire) next_state = SHIFT;
      end
      SHIFT: begin
        if (shift_xfer && bit_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          next_state = PARITY;
`else
          next_state = load_fire ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (beat_xfer) next_state = load_fire ? SHIFT : IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  bit_cnt_in_range: assert property (@(posedge clk) disable iff (rst) bit_cnt <= CW'(N - 1));

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB- and LSB-first instances share stimulus and a beat-queue model.
module tb_piso_serializer;

  localparam int N = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = N + 1;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = N;
`endif

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         load_valid = 1'b0;
  logic         ser_ready  = 1'b0;
  logic [N-1:0] load_data  = '0;

  logic m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy;
  logic l_load_ready, l_ser_valid, l_ser_out, l_ser_last, l_busy;

  always #5 clk = ~clk;

  piso_serializer #(.N(N), .MSB_FIRST(1)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .load_data  (load_data),
    .ser_valid  (m_ser_valid),
    .ser_ready  (ser_ready),
    .ser_out    (m_ser_out),
    .ser_last   (m_ser_last),
    .busy       (m_busy)
  );

  piso_serializer #(.N(N), .MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .load_data  (load_data),
    .ser_valid  (l_ser_valid),
    .ser_ready  (ser_ready),
    .ser_out    (l_ser_out),
    .ser_last   (l_ser_last),
    .busy       (l_busy)
  );

  typedef struct {
    logic b_msb;
    logic b_lsb;
    logic last;
  } beat_t;

  typedef struct {
    logic [N-1:0] word;
    logic [7:0]   ready_pat;
    logic         exp_par;
  } vec_t;

  beat_t model_q[$];
  vec_t  vecs[6];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] got_msb, got_lsb;
  int          beats;
  int          cur_run, max_run;
  logic        last_fire, fire_on_final;
  int          loads;
  logic        saw_final_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A frame is the word's bits in send order, then the parity beat when enabled.
  task automatic push_word(input logic [N-1:0] w);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.b_msb = w[N-1-i];
      b.b_lsb = w[i];
      b.last  = !PAR && (i == N - 1);
      model_q.push_back(b);
    end
    if (PAR) begin
      b.b_msb = ^w;
      b.b_lsb = ^w;
      b.last  = 1'b1;
      model_q.push_back(b);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic       ev, er, em, el, elast, xfer, fire;
    logic [9:0] act, exp;
    @(negedge clk);
    ev    = (model_q.size() > 0);
    em    = ev ? model_q[0].b_msb : 1'b0;
    el    = ev ? model_q[0].b_lsb : 1'b0;
    elast = ev ? model_q[0].last  : 1'b0;
    er    = !ev || (model_q.size() == 1 && ser_ready);
    act = {m_ser_valid, m_ser_out, m_ser_last, m_busy, m_load_ready,
           l_ser_valid, l_ser_out, l_ser_last, l_busy, l_load_ready};
    exp = {ev, em, elast, ev, er, ev, el, elast, ev, er};
    check("cycle_outputs", {22'd0, act}, {22'd0, exp});
    xfer = ev && ser_ready;
    fire = load_valid && er;
    fire_on_final = fire && xfer && (model_q.size() == 1);
    if (xfer) begin
      got_msb = {got_msb[30:0], m_ser_out};
      got_lsb = {got_lsb[30:0], l_ser_out};
      beats++;
    end
    if (m_ser_valid) cur_run++;
    else cur_run = 0;
    if (cur_run > max_run) max_run = cur_run;
    @(posedge clk);
    if (xfer) void'(model_q.pop_front());
    if (fire) push_word(load_data);
    last_fire = fire;
    #1;
  endtask

  task automatic load_word(input logic [N-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (last_fire) break;
    end
    check("load_accept", {31'd0, last_fire}, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] exp_m, exp_l;
    got_msb = '0;
    got_lsb = '0;
    beats   = 0;
    load_word(v.word);
    for (int k = 0; k < 200 && model_q.size() > 0; k++) begin
      ser_ready = v.ready_pat[k % 8];
      cycle();
    end
    check("frame_drain", model_q.size(), 32'd0);
    check("frame_beats", beats, FRAME);
    exp_m = {24'd0, v.word};
    exp_l = '0;
    for (int i = 0; i < N; i++) exp_l = {exp_l[30:0], v.word[i]};
    if (PAR) begin
      exp_m = {exp_m[30:0], v.exp_par};
      exp_l = {exp_l[30:0], v.exp_par};
    end
    check("frame_msb_stream", got_msb, exp_m);
    check("frame_lsb_stream", got_lsb, exp_l);
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, ready_pat: 8'hFF, exp_par: 1'b0};
    vecs[1] = '{word: 8'h01, ready_pat: 8'hFF, exp_par: 1'b1};
    vecs[2] = '{word: 8'hC3, ready_pat: 8'b1001_1001, exp_par: 1'b0};
    vecs[3] = '{word: 8'h07, ready_pat: 8'hFF, exp_par: 1'b1};
    vecs[4] = '{word: 8'h03, ready_pat: 8'hFF, exp_par: 1'b0};
    vecs[5] = '{word: 8'h6E, ready_pat: 8'b0110_1011, exp_par: 1'b1};
    cur_run = 0;
    max_run = 0;
    last_fire = 1'b0;

    // Reset held: outputs idle, block ready to load.
    #12;
    check("reset_hold", {27'd0, m_ser_valid, m_ser_out, m_ser_last, m_busy, m_load_ready}, 32'd1);
    #5 rst = 1'b0;
    cycle();

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset mid-frame aborts immediately and the frame is not resumed.
    ser_ready = 1'b1;
    load_word(8'h3C);
    cycle();
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check("rst_async_idle", {28'd0, m_ser_valid, m_busy, l_ser_valid, l_busy}, 32'd0);
    model_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    cycle();
    check("rst_release", {30'd0, m_load_ready, m_ser_out}, 32'd2);

    // Back-to-back: second word accepted on the first word's final beat, no bubble.
    got_msb = '0;
    got_lsb = '0;
    beats = 0;
    cur_run = 0;
    max_run = 0;
    loads = 0;
    saw_final_fire = 1'b0;
    ser_ready = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hFF;
    for (int k = 0; k < 100 && loads < 2; k++) begin
      cycle();
      if (last_fire) begin
        loads++;
        if (fire_on_final) saw_final_fire = 1'b1;
        if (loads == 1) load_data = 8'h00;
        else load_valid = 1'b0;
      end
    end
    for (int k = 0; k < 100 && model_q.size() > 0; k++) cycle();
    cycle();
    check("b2b_loads", loads, 32'd2);
    check("b2b_load_on_final", {31'd0, saw_final_fire}, 32'd1);
    check("b2b_contiguous", max_run, 2 * FRAME);
    check("b2b_beats", beats, 2 * FRAME);

    // Random traffic against the beat-queue model.
    for (int k = 0; k < 600; k++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = N'($urandom);
      ser_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    for (int k = 0; k < 100 && model_q.size() > 0; k++) cycle();
    cycle();
    check("rand_drain", model_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
